// File: rtl/double_dabble_bcd2bin_if.sv
// Handshake/bus bundle for the BCD-to-binary converter: operand request in, result out.
interface double_dabble_bcd2bin_if #(
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned WIDTH      = $clog2(10 ** NUM_DIGITS)
);
    logic             start;
    logic [3:0]       bcd [NUM_DIGITS];
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] bin;
    logic             err;

    modport master (output start, bcd, input busy, done, bin, err);
    modport slave  (input start, bcd, output busy, done, bin, err);
endinterface

// File: rtl/double_dabble_bcd2bin.sv
// Sequential BCD-to-binary converter (reverse double dabble): one SHIFT plus one ADJUST
// cycle per result bit, finishing with a single-cycle done pulse.
module double_dabble_bcd2bin #(
    parameter int unsigned NUM_DIGITS  = 3,
    parameter int unsigned WIDTH       = $clog2(10 ** NUM_DIGITS),
    parameter bit          CHECK_PARAM = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    double_dabble_bcd2bin_if.slave  bus
);
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (CHECK_PARAM && (NUM_DIGITS == 0 || NUM_DIGITS > 9 ||
                        WIDTH < $clog2(10 ** NUM_DIGITS))) begin : g_param_bad
        $fatal(1, "double_dabble_bcd2bin: illegal NUM_DIGITS/WIDTH combination");
    end

    typedef enum logic [1:0] {IDLE, SHIFT, ADJUST} state_e;

    state_e             state_q, state_d;
    logic [3:0]         bcd_q [NUM_DIGITS];
    logic [3:0]         bcd_d [NUM_DIGITS];
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               inv_q, inv_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   bin_q, bin_d;
    logic               err_q, err_d;
    logic               any_gt9;
    logic               last_iter;
    logic               rem_nz;

    always_comb begin
        any_gt9 = 1'b0;
        rem_nz  = 1'b0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            any_gt9 = any_gt9 | (bus.bcd[i] > 4'd9);
            rem_nz  = rem_nz  | (bcd_d[i] != 4'd0);
        end
    end

    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        done_d  = 1'b0;
        bin_d   = bin_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    bcd_d   = bus.bcd;
                    acc_d   = '0;
                    cnt_d   = '0;
                    inv_d   = any_gt9;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // Whole {digits, acc} chain moves right by one; zero enters the top digit.
                acc_d = {bcd_q[0][0], acc_q[WIDTH-1:1]};
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    bcd_d[i] = {1'b0, bcd_q[i][3:1]};
                end
                for (int unsigned i = 0; i + 1 < NUM_DIGITS; i++) begin
                    bcd_d[i][3] = bcd_q[i+1][0];
                end
                state_d = ADJUST;
            end
            ADJUST: begin
                for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                    if (bcd_q[i] >= 4'd8) bcd_d[i] = bcd_q[i] - 4'd3;
                end
                if (last_iter) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = inv_q;
                    bin_d   = inv_q ? '0 : acc_q;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Control and visible outputs: cleared immediately on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bin_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bin_q   <= bin_d;
            err_q   <= err_d;
        end
    end

    // Datapath working registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        bcd_q <= bcd_d;
        acc_q <= acc_d;
        cnt_q <= cnt_d;
        inv_q <= inv_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst_n && state_q == ADJUST && last_iter && !inv_q) begin
            assert (!rem_nz) else $error("double_dabble_bcd2bin: residual BCD digits nonzero");
        end
    end
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.bin  = bin_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_double_dabble_bcd2bin.sv
// Self-checking bench: decimal-arithmetic reference model compared every cycle, plus
// directed literal cases and exhaustive 1- and 2-digit sweeps.
module tb_double_dabble_bcd2bin;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;

    int total = 0;
    int bad   = 0;

    double_dabble_bcd2bin_if #(.NUM_DIGITS(3), .WIDTH(10)) bus0 ();
    double_dabble_bcd2bin_if #(.NUM_DIGITS(1), .WIDTH(4))  bus1 ();
    double_dabble_bcd2bin_if #(.NUM_DIGITS(2), .WIDTH(7))  bus2 ();

    double_dabble_bcd2bin #(.NUM_DIGITS(3), .WIDTH(10), .CHECK_PARAM(1'b1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    double_dabble_bcd2bin #(.NUM_DIGITS(1), .WIDTH(4), .CHECK_PARAM(1'b1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    double_dabble_bcd2bin #(.NUM_DIGITS(2), .WIDTH(7), .CHECK_PARAM(1'b1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a conversion is a countdown of 2*WIDTH edges ending in the decimal value.
    int m_cnt  = 0;
    int m_val  = 0;
    bit m_inv  = 1'b0;
    bit m_busy = 1'b0;
    bit m_done = 1'b0;
    int m_bin  = 0;
    bit m_err  = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_bin = 0; m_err = 1'b0; m_cnt = 0;
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                if (bus0.start) begin
                    m_busy = 1'b1;
                    m_cnt  = 20;
                    m_val  = 0;
                    m_inv  = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        m_val = m_val + int'(bus0.bcd[i]) * (10 ** i);
                        if (bus0.bcd[i] > 4'd9) m_inv = 1'b1;
                    end
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_bin  = m_inv ? 0 : m_val;
                    m_err  = m_inv;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", int'(bus0.busy), int'(m_busy));
            chk("cyc_done", int'(bus0.done), int'(m_done));
            chk("cyc_bin",  int'(bus0.bin),  m_bin);
            chk("cyc_err",  int'(bus0.err),  int'(m_err));
        end
    end

    task automatic run3(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0,
                        input int exp_bin, input bit exp_err, input string name);
        int lat;
        @(negedge clk);
        bus0.bcd[2] = d2; bus0.bcd[1] = d1; bus0.bcd[0] = d0;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        lat = 0;
        while (!bus0.done && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_lat"}, lat, 20);
        chk({name, "_bin"}, int'(bus0.bin), exp_bin);
        chk({name, "_err"}, int'(bus0.err), int'(exp_err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int lat;
        int last_bin;
        logic [3:0] r2, r1, r0;
        bit inv;

        bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
        for (int i = 0; i < 3; i++) bus0.bcd[i] = 4'd0;
        bus1.bcd[0] = 4'd0;
        bus2.bcd[0] = 4'd0; bus2.bcd[1] = 4'd0;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_done", int'(bus0.done), 0);
        chk("rst_bin",  int'(bus0.bin),  0);
        chk("rst_err",  int'(bus0.err),  0);
        chk_en = 1'b1;

        // Zero operand with busy window tracked edge by edge.
        bus0.bcd[2] = 4'd0; bus0.bcd[1] = 4'd0; bus0.bcd[0] = 4'd0;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        for (int e = 0; e <= 20; e++) begin
            if (e > 0) @(negedge clk);
            chk("zero_busy", int'(bus0.busy), (e < 20) ? 1 : 0);
            chk("zero_done", int'(bus0.done), (e == 20) ? 1 : 0);
        end
        chk("zero_bin", int'(bus0.bin), 0);

        run3(4'd2, 4'd5, 4'd5, 10'h0FF, 1'b0, "d255");
        run3(4'd9, 4'd9, 4'd9, 10'h3E7, 1'b0, "d999");
        run3(4'd4, 4'd0, 4'd9, 10'h199, 1'b0, "d409");
        run3(4'd1, 4'hA, 4'd3, 0,       1'b1, "inv1A3");
        run3(4'd0, 4'd4, 4'd2, 10'h02A, 1'b0, "d042");

        // Back-to-back with start held high.
        @(negedge clk);
        bus0.bcd[2] = 4'd1; bus0.bcd[1] = 4'd2; bus0.bcd[0] = 4'd3;
        bus0.start = 1'b1;
        nd = 0;
        for (int e = 0; e <= 62; e++) begin
            @(negedge clk);
            if (bus0.done) begin
                chk("b2b_edge", e, 20 + 21 * nd);
                chk("b2b_bin", int'(bus0.bin), 10'h07B);
                nd++;
            end
        end
        bus0.start = 1'b0;
        chk("b2b_count", nd, 3);
        repeat (3) @(negedge clk);

        // Start pulses and operand changes while busy must be ignored.
        bus0.bcd[2] = 4'd7; bus0.bcd[1] = 4'd7; bus0.bcd[0] = 4'd7;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        nd = 0;
        last_bin = -1;
        for (int c = 1; c <= 45; c++) begin
            if (bus0.done) begin nd++; last_bin = int'(bus0.bin); end
            if (c >= 3 && c <= 10) begin
                bus0.start = 1'($urandom_range(0, 1));
                for (int i = 0; i < 3; i++) bus0.bcd[i] = 4'($urandom_range(0, 15));
            end else begin
                bus0.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_count", nd, 1);
        chk("ign_bin", last_bin, 777);

        // Reset mid-conversion.
        bus0.bcd[2] = 4'd8; bus0.bcd[1] = 4'd8; bus0.bcd[0] = 4'd8;
        bus0.start = 1'b1;
        @(posedge clk);
        #1 bus0.start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(bus0.busy), 0);
        chk("mid_rst_done", int'(bus0.done), 0);
        chk("mid_rst_bin",  int'(bus0.bin),  0);
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (bus0.done) nd++;
        end
        chk("mid_rst_nodone", nd, 0);
        run3(4'd0, 4'd0, 4'd5, 5, 1'b0, "d005");

        // Random operands, mostly valid, some with digits above nine.
        for (int k = 0; k < 30; k++) begin
            r2 = 4'($urandom_range(0, 11));
            r1 = 4'($urandom_range(0, 11));
            r0 = 4'($urandom_range(0, 11));
            inv = (r2 > 4'd9) || (r1 > 4'd9) || (r0 > 4'd9);
            run3(r2, r1, r0, inv ? 0 : int'(r2) * 100 + int'(r1) * 10 + int'(r0), inv, "rand");
        end

        // Exhaustive single-digit sweep plus one invalid digit.
        for (int v = 0; v <= 10; v++) begin
            @(negedge clk);
            bus1.bcd[0] = (v == 10) ? 4'd12 : 4'(v);
            bus1.start = 1'b1;
            @(negedge clk);
            bus1.start = 1'b0;
            lat = 0;
            while (!bus1.done && lat < 100) begin @(negedge clk); lat++; end
            chk("sw1_lat", lat, 8);
            chk("sw1_bin", int'(bus1.bin), (v == 10) ? 0 : v);
            chk("sw1_err", int'(bus1.err), (v == 10) ? 1 : 0);
        end

        // Exhaustive two-digit sweep.
        for (int v = 0; v < 100; v++) begin
            @(negedge clk);
            bus2.bcd[1] = 4'(v / 10);
            bus2.bcd[0] = 4'(v % 10);
            bus2.start = 1'b1;
            @(negedge clk);
            bus2.start = 1'b0;
            lat = 0;
            while (!bus2.done && lat < 100) begin @(negedge clk); lat++; end
            chk("sw2_lat", lat, 14);
            chk("sw2_bin", int'(bus2.bin), v);
            chk("sw2_err", int'(bus2.err), 0);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/double_dabble_bcd2bin.md
# double_dabble_bcd2bin

Sequential BCD-to-binary converter using the reverse double-dabble algorithm (shift right, subtract 3 from digits ≥ 8). It is the inverse companion of the bin2bcd converter. It accepts a NUM_DIGITS-digit BCD value on a start pulse and returns the binary value with a one-cycle done pulse. It sits on the input path of the multiplier display/console logic, turning operator-entered decimal operands into binary.

## Interface
- NUM_DIGITS, default 3: BCD digits accepted; legal range 1..9.
- WIDTH, default $clog2(10**NUM_DIGITS) (10 for 3 digits): binary result width.
- CHECK_PARAM, default 1: when 1, simulation-only $fatal if NUM_DIGITS < 1 or NUM_DIGITS > 9, or WIDTH < $clog2(10**NUM_DIGITS).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset; asynchronous, active-low.
- start  input  1  request a conversion; sampled only in IDLE.
- bcd  input  [3:0] x NUM_DIGITS (unpacked, bcd[0] = least significant digit)  operand; sampled on the accepting edge only.
- busy  output  1  conversion in progress (state != IDLE).
- done  output  1  one-cycle pulse: bin/err valid and updated.
- bin  output  WIDTH  result; holds its value until the next done.
- err  output  1  last conversion had a digit > 9; holds with bin.

## Operation
- FSM states: IDLE, SHIFT, ADJUST. Reset state is IDLE.
- IDLE + start=1 at an edge:
  - load bcd_reg ← bcd, bin_reg ← 0, iteration count ← 0.
  - invalid ← OR over digits of (digit > 9).
  - go to SHIFT.
- IDLE + start=0: stay in IDLE.
- SHIFT:
  - shift the concatenation {bcd_reg[NUM_DIGITS-1] … bcd_reg[0], bin_reg} right by 1, with 0 into the top digit's bit 3.
  - bin_reg[WIDTH-1] ← bcd_reg[0][0].
  - digit i bit 3 ← digit i+1 bit 0.
  - go to ADJUST.
- ADJUST:
  - every digit in parallel: if digit ≥ 8 then digit ← digit − 3 (4-bit); else unchanged.
  - if count == WIDTH−1: go to IDLE and complete.
  - otherwise count ← count + 1 and go to SHIFT.
- Completion, on the same edge as the final ADJUST:
  - done ← 1, err ← invalid.
  - bin ← invalid ? 0 : bin_reg.
- done deasserts on the following edge.
- After WIDTH iterations bcd_reg is zero for any valid input. Implementation may assert this in simulation.
- start while busy=1 is ignored; no queueing.
- bcd changes after the accepting edge have no effect.
- Count width: $clog2(WIDTH), minimum 1 bit.

## Timing
- Reset values: busy=0, done=0, bin=0, err=0, state=IDLE. Internal bcd_reg/bin_reg/count need no reset.
- Let edge 0 be the edge that samples start=1 in IDLE:
  - busy is high from edge 0 through edge 2·WIDTH.
  - done is high for exactly one cycle, from edge 2·WIDTH to edge 2·WIDTH+1.
  - Latency is 20 edges for the default configuration.
- Back-to-back: start=1 during the done cycle is accepted at edge 2·WIDTH+1 (state is IDLE). Throughput is one conversion per 2·WIDTH+1 cycles.
- rst_n low at any point, mid-conversion included: all outputs and the FSM return to reset values immediately.
  - No done pulse is produced for the aborted conversion.
  - After rst_n deasserts, the next start begins a fresh conversion.
- bin and err change only on a done edge or on reset.

## Test plan
- Reset, then start with bcd={0,0,0} (digits 2,1,0) → done at edge 20, bin=0, err=0; busy high exactly edges 0..20.
- bcd={2,5,5} → bin=10'h0FF, err=0. Then bcd={9,9,9} → bin=10'h3E7. Then bcd={4,0,9} → bin=10'h199.
- Back-to-back: start held high continuously with bcd={1,2,3} → done pulses at edges 20, 41, 62, each with bin=10'h07B; no start is dropped or double-counted.
- Invalid: bcd={1,10,3} (hex A in the middle digit) → done at edge 20, err=1, bin=0. A following valid {0,4,2} → err=0, bin=10'h02A.
- Ignored start and input stability: pulse start during cycles 3..10 of a {7,7,7} conversion and toggle bcd → exactly one done, bin=10'h309 (777).
- Reset mid-conversion: assert rst_n low at edge 9 of a {8,8,8} conversion → busy=0, done=0, bin=0 immediately, no late done pulse. A new {0,0,5} conversion then yields bin=5.
- Parameter sweep: NUM_DIGITS=1 (WIDTH=4) and NUM_DIGITS=2 (WIDTH=7), exhaustively over all valid inputs, compared against a decimal reference model; latency 2·WIDTH each.
